// File: rtl/montgomery_axil_pkg.sv
// Shared definitions for the Montgomery multiplier AXI4-Lite register block.
// Contents: byte offsets of the register map, AXI response codes, the ID
// constant and bit positions inside CTRL and STATUS.
package montgomery_axil_pkg;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_INDEX  = 6'h08;
  localparam logic [5:0] ADDR_A      = 6'h0C;
  localparam logic [5:0] ADDR_B      = 6'h10;
  localparam logic [5:0] ADDR_M      = 6'h14;
  localparam logic [5:0] ADDR_RESULT = 6'h18;
  localparam logic [5:0] ADDR_ID     = 6'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] ID_VALUE = 32'h4D4F4E54;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/montgomery_axil_wordbank.sv
// NWORDS x 32-bit word store behind one indexed 32-bit window.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears all words)
//   we, idx       byte-strobed write of word idx (wstrb/wdata)
//   load          parallel load of every word from load_data (wins over we)
//   rdata         word currently selected by idx
//   flat          all words concatenated, word 0 in the least significant bits
module montgomery_axil_wordbank
  import montgomery_axil_pkg::*;
#(
  parameter int NWORDS = 16,
  parameter int IDXW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDXW-1:0]        idx,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            wdata,
  input  logic                   load,
  input  logic [NWORDS*32-1:0]   load_data,
  output logic [31:0]            rdata,
  output logic [NWORDS*32-1:0]   flat
);

  logic [NWORDS-1:0][31:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= load_data;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];
  assign flat  = mem;

endmodule

// File: rtl/montgomery_axil_regs.sv
// AXI4-Lite responder in front of the Montgomery multiplier core.
// Ports:
//   S_AXI_*         AXI4-Lite slave (AW/W/B/AR/R), ACLK clock, ARESET async active-high
//   core_a/b/m_o    operand buses, driven continuously from the word banks
//   core_start_o    one-cycle start pulse to the core
//   core_done_i     one-cycle done pulse; core_result_i valid alongside it
//   irq_o           STATUS.done & CTRL.irq_en
module montgomery_axil_regs
  import montgomery_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int OP_WIDTH           = 512
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [OP_WIDTH-1:0]             core_a_o,
  output logic [OP_WIDTH-1:0]             core_b_o,
  output logic [OP_WIDTH-1:0]             core_m_o,
  output logic                            core_start_o,
  input  logic                            core_done_i,
  input  logic [OP_WIDTH-1:0]             core_result_i,
  output logic                            irq_o
);

  localparam int          NWORDS   = OP_WIDTH / 32;
  localparam int          IDXW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] NWORDS_W = 32'(NWORDS);

  // ready_en keeps every ready low while in reset and for the first cycle after.
  logic        ready_en;
  logic        aw_held, w_held;
  logic [3:0]  aw_word;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid_r, rvalid_r;
  logic [1:0]  bresp_r, rresp_r;
  logic [31:0] rdata_r;
  logic        irq_en, busy, done, start_r;
  logic [31:0] index_r;

  logic        aw_hs, w_hs, ar_hs, wr_fire, idx_ok, result_load;
  logic [5:0]  wr_off, rd_off;
  logic [31:0] wmask;
  logic [IDXW-1:0] bank_idx;
  logic [31:0] a_rdata, b_rdata, m_rdata, res_rdata;
  logic [OP_WIDTH-1:0] unused_result_flat;
  logic        unused_bits;

  logic wr_err, we_a, we_b, we_m, we_index, we_ctrl, w1c_done, start_req;
  logic rd_err;
  logic [31:0] rd_val;

  assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid_r;
  assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid_r;
  assign S_AXI_ARREADY = ready_en & ~rvalid_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign core_start_o  = start_r;
  assign irq_o         = done & irq_en;

  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign wr_fire = aw_held & w_held;
  assign wr_off  = {aw_word, 2'b00};
  assign rd_off  = {S_AXI_ARADDR[5:2], 2'b00};

  // Out-of-range INDEX is rejected before any bank access, so only the low bits reach the banks.
  assign idx_ok      = index_r < NWORDS_W;
  assign bank_idx    = index_r[IDXW-1:0];
  assign wmask       = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign result_load = core_done_i & busy;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         unused_result_flat};

  always_comb begin
    wr_err    = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    we_m      = 1'b0;
    we_index  = 1'b0;
    we_ctrl   = 1'b0;
    w1c_done  = 1'b0;
    start_req = 1'b0;
    if (wr_fire) begin
      case (wr_off)
        ADDR_CTRL: begin
          we_ctrl   = w_strb[0];
          start_req = w_strb[0] & w_data[CTRL_START_BIT] & ~busy;
        end
        ADDR_STATUS: w1c_done = w_strb[0] & w_data[STATUS_DONE_BIT];
        ADDR_INDEX:  if (busy) wr_err = 1'b1; else we_index = 1'b1;
        ADDR_A:      if (busy || !idx_ok) wr_err = 1'b1; else we_a = 1'b1;
        ADDR_B:      if (busy || !idx_ok) wr_err = 1'b1; else we_b = 1'b1;
        ADDR_M:      if (busy || !idx_ok) wr_err = 1'b1; else we_m = 1'b1;
        default:     wr_err = 1'b1;  // RESULT, ID and unmapped slots
      endcase
    end
  end

  always_comb begin
    rd_err = 1'b0;
    rd_val = '0;
    case (rd_off)
      ADDR_CTRL:   rd_val[CTRL_IRQ_EN_BIT] = irq_en;
      ADDR_STATUS: begin
        rd_val[STATUS_BUSY_BIT] = busy;
        rd_val[STATUS_DONE_BIT] = done;
      end
      ADDR_INDEX:  rd_val = index_r;
      ADDR_A:      if (idx_ok) rd_val = a_rdata;   else rd_err = 1'b1;
      ADDR_B:      if (idx_ok) rd_val = b_rdata;   else rd_err = 1'b1;
      ADDR_M:      if (idx_ok) rd_val = m_rdata;   else rd_err = 1'b1;
      ADDR_RESULT: if (idx_ok) rd_val = res_rdata; else rd_err = 1'b1;
      ADDR_ID:     rd_val = ID_VALUE;
      default:     rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_word  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= '0;
      irq_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      start_r  <= 1'b0;
      index_r  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_word <= S_AXI_AWADDR[5:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA[31:0];
        w_strb <= S_AXI_WSTRB[3:0];
      end
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_r <= 1'b1;
        bresp_r  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_val;
        rresp_r  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_r && S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end

      if (we_index) index_r <= (index_r & ~wmask) | (w_data & wmask);
      if (we_ctrl)  irq_en  <= w_data[CTRL_IRQ_EN_BIT];
      start_r <= start_req;

      // start_req needs busy=0 and result_load needs busy=1, so they never collide;
      // a completing operation outranks a same-cycle done clear.
      if (result_load) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (start_req) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (w1c_done) begin
        done <= 1'b0;
      end
    end
  end

  montgomery_axil_wordbank #(.NWORDS(NWORDS), .IDXW(IDXW)) u_bank_a (
    .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .we(we_a), .idx(bank_idx), .wstrb(w_strb),
    .wdata(w_data), .load(1'b0), .load_data('0), .rdata(a_rdata), .flat(core_a_o)
  );

  montgomery_axil_wordbank #(.NWORDS(NWORDS), .IDXW(IDXW)) u_bank_b (
    .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .we(we_b), .idx(bank_idx), .wstrb(w_strb),
    .wdata(w_data), .load(1'b0), .load_data('0), .rdata(b_rdata), .flat(core_b_o)
  );

  montgomery_axil_wordbank #(.NWORDS(NWORDS), .IDXW(IDXW)) u_bank_m (
    .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .we(we_m), .idx(bank_idx), .wstrb(w_strb),
    .wdata(w_data), .load(1'b0), .load_data('0), .rdata(m_rdata), .flat(core_m_o)
  );

  // Result store: never written over the bus, only parallel-loaded on done.
  montgomery_axil_wordbank #(.NWORDS(NWORDS), .IDXW(IDXW)) u_bank_result (
    .clk(S_AXI_ACLK), .rst(S_AXI_ARESET), .we(1'b0), .idx(bank_idx), .wstrb(4'b0000),
    .wdata(32'h0), .load(result_load), .load_data(core_result_i), .rdata(res_rdata),
    .flat(unused_result_flat)
  );

endmodule

// File: tb/tb_montgomery_axil_regs.sv
// Directed bench for montgomery_axil_regs: register access, handshake ordering,
// start/done flow, error responses, byte strobes and reset mid-operation.
module tb_montgomery_axil_regs;

  logic         tb_ACLK = 1'b0;
  logic         S_AXI_ARESET = 1'b1;
  logic [5:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [5:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b1;
  logic [511:0] core_a_o, core_b_o, core_m_o;
  logic         core_start_o;
  logic         core_done_i = 1'b0;
  logic [511:0] core_result_i = '0;
  logic         irq_o;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int s0;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;

  always #5 tb_ACLK = ~tb_ACLK;

  always @(negedge tb_ACLK) if (core_start_o) start_cnt = start_cnt + 1;

  montgomery_axil_regs dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .core_a_o(core_a_o), .core_b_o(core_b_o), .core_m_o(core_m_o),
    .core_start_o(core_start_o), .core_done_i(core_done_i),
    .core_result_i(core_result_i), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write with independent AW/W start delays (in cycles) and BREADY held low b_dly cycles.
  task automatic axi_wr(input string tag, input logic [5:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp,
                        input int aw_dly, input int w_dly, input int b_dly);
    int n;
    bit aw_done, w_done, aw_f, w_f;
    logic [1:0] resp;
    aw_done = 0; w_done = 0; n = 0;
    S_AXI_BREADY = 1'b0;
    @(negedge tb_ACLK);
    while (!(aw_done && w_done) && n < 100) begin
      if (!aw_done && n == aw_dly) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1; end
      if (!w_done && n == w_dly) begin
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      end
      aw_f = S_AXI_AWVALID & S_AXI_AWREADY;
      w_f  = S_AXI_WVALID & S_AXI_WREADY;
      @(negedge tb_ACLK);
      n++;
      if (aw_f) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_f)  begin S_AXI_WVALID = 1'b0;  w_done = 1;  end
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check({tag, "_accepted"}, {31'b0, aw_done & w_done}, 32'd1);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge tb_ACLK); n++; end
    check({tag, "_bvalid"}, {31'b0, S_AXI_BVALID}, 32'd1);
    resp = S_AXI_BRESP;
    check({tag, "_bresp"}, {30'b0, resp}, {30'b0, exp_resp});
    for (int i = 0; i < b_dly; i++) begin
      @(negedge tb_ACLK);
      check({tag, "_bhold"}, {29'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'b100);
      check({tag, "_bstable"}, {30'b0, S_AXI_BRESP}, {30'b0, resp});
    end
    S_AXI_BREADY = 1'b1;
    @(negedge tb_ACLK);
    S_AXI_BREADY = 1'b0;
    check({tag, "_bdone"}, {31'b0, S_AXI_BVALID}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [5:0] addr, input logic [31:0] data,
                    input logic [1:0] exp_resp);
    axi_wr(tag, addr, data, 4'hF, exp_resp, 0, 0, 0);
  endtask

  task automatic rd(input string tag, input logic [5:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    int n;
    bit acc, ar_f;
    acc = 0; n = 0;
    @(negedge tb_ACLK);
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    while (!acc && n < 50) begin
      ar_f = S_AXI_ARREADY;
      @(negedge tb_ACLK);
      n++;
      if (ar_f) begin S_AXI_ARVALID = 1'b0; acc = 1; end
    end
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge tb_ACLK); n++; end
    check({tag, "_rvalid"}, {31'b0, S_AXI_RVALID}, 32'd1);
    rd_d = S_AXI_RDATA;
    rd_r = S_AXI_RRESP;
    check({tag, "_rdata"}, rd_d, exp_data);
    check({tag, "_rresp"}, {30'b0, rd_r}, {30'b0, exp_resp});
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge tb_ACLK);
    check("rst_readys", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check("rst_valids", {28'b0, S_AXI_BVALID, S_AXI_RVALID, core_start_o, irq_o}, 32'd0);
    S_AXI_ARESET = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    rd("rst_status", 6'h04, 32'h0, 2'b00);
    rd("rst_index", 6'h08, 32'h0, 2'b00);

    // Register write/read-back
    wr("idx0", 6'h08, 32'h0, 2'b00);
    wr("wa0", 6'h0C, 32'h0101FFFF, 2'b00);
    wr("wb0", 6'h10, 32'hABCD0001, 2'b00);
    wr("wm0", 6'h14, 32'hDEAD0011, 2'b00);
    rd("ra0", 6'h0C, 32'h0101FFFF, 2'b00);
    rd("rb0", 6'h10, 32'hABCD0001, 2'b00);
    rd("rm0", 6'h14, 32'hDEAD0011, 2'b00);
    check("bus_a0", core_a_o[31:0], 32'h0101FFFF);
    check("bus_m0", core_m_o[31:0], 32'hDEAD0011);
    rd("id", 6'h1C, 32'h4D4F4E54, 2'b00);
    rd("id_lowbits", 6'h1F, 32'h4D4F4E54, 2'b00);

    // Handshake ordering: W leads AW by 3, then AW leads W by 3; B held 5 cycles
    wr("idx3", 6'h08, 32'h3, 2'b00);
    axi_wr("w_first", 6'h0C, 32'hBEEF0011, 4'hF, 2'b00, 3, 0, 5);
    rd("ra3", 6'h0C, 32'hBEEF0011, 2'b00);
    rd("rindex3", 6'h08, 32'h3, 2'b00);
    check("bus_a3", core_a_o[127:96], 32'hBEEF0011);
    check("bus_a0_kept", core_a_o[31:0], 32'h0101FFFF);
    axi_wr("aw_first", 6'h10, 32'h00005A5A, 4'hF, 2'b00, 0, 3, 5);
    rd("rb3", 6'h10, 32'h00005A5A, 2'b00);
    check("bus_b3", core_b_o[127:96], 32'h00005A5A);

    // Byte strobes
    wr("idx0b", 6'h08, 32'h0, 2'b00);
    wr("wa_ones", 6'h0C, 32'hFFFFFFFF, 2'b00);
    axi_wr("wa_strb", 6'h0C, 32'h00000000, 4'b0101, 2'b00, 0, 0, 0);
    rd("ra_strb", 6'h0C, 32'hFF00FF00, 2'b00);

    // Error responses
    rd("unmapped_rd", 6'h24, 32'h0, 2'b10);
    wr("unmapped_wr", 6'h30, 32'h1234, 2'b10);
    wr("idx16", 6'h08, 32'd16, 2'b00);
    rd("ra_badidx", 6'h0C, 32'h0, 2'b10);
    rd("rres_badidx", 6'h18, 32'h0, 2'b10);
    wr("wa_badidx", 6'h0C, 32'h55555555, 2'b10);
    wr("idx0c", 6'h08, 32'h0, 2'b00);
    wr("wid", 6'h1C, 32'h1, 2'b10);
    wr("wres", 6'h18, 32'h1, 2'b10);
    rd("id_after_wr", 6'h1C, 32'h4D4F4E54, 2'b00);
    rd("ra_after_err", 6'h0C, 32'hFF00FF00, 2'b00);

    // Operation
    s0 = start_cnt;
    wr("start", 6'h00, 32'h3, 2'b00);
    repeat (2) @(negedge tb_ACLK);
    check("start_pulses", start_cnt - s0, 32'd1);
    rd("status_busy", 6'h04, 32'h1, 2'b00);
    rd("ctrl_rd", 6'h00, 32'h2, 2'b00);
    wr("wa_busy", 6'h0C, 32'h11111111, 2'b10);
    wr("widx_busy", 6'h08, 32'h2, 2'b10);
    wr("start_busy", 6'h00, 32'h3, 2'b00);
    repeat (2) @(negedge tb_ACLK);
    check("start_busy_ignored", start_cnt - s0, 32'd1);
    rd("ra_busy_kept", 6'h0C, 32'hFF00FF00, 2'b00);
    rd("rindex_busy_kept", 6'h08, 32'h0, 2'b00);
    check("irq_before_done", {31'b0, irq_o}, 32'd0);
    @(negedge tb_ACLK);
    core_result_i = '0;
    core_result_i[31:0] = 32'h12345678;
    core_result_i[63:32] = 32'hCAFEF00D;
    core_done_i = 1'b1;
    @(negedge tb_ACLK);
    core_done_i = 1'b0;
    check("irq_done", {31'b0, irq_o}, 32'd1);
    rd("status_done", 6'h04, 32'h2, 2'b00);
    rd("result0", 6'h18, 32'h12345678, 2'b00);
    wr("idx1", 6'h08, 32'h1, 2'b00);
    rd("result1", 6'h18, 32'hCAFEF00D, 2'b00);
    wr("idx0d", 6'h08, 32'h0, 2'b00);
    // done while idle must be ignored
    @(negedge tb_ACLK);
    core_result_i[31:0] = 32'hDEADBEEF;
    core_done_i = 1'b1;
    @(negedge tb_ACLK);
    core_done_i = 1'b0;
    rd("result_idle_done", 6'h18, 32'h12345678, 2'b00);
    wr("w1c_keep", 6'h04, 32'h1, 2'b00);
    rd("status_w1c_bit0", 6'h04, 32'h2, 2'b00);
    wr("w1c_done", 6'h04, 32'h2, 2'b00);
    rd("status_clr", 6'h04, 32'h0, 2'b00);
    check("irq_clr", {31'b0, irq_o}, 32'd0);

    // Reset mid-operation with a write response pending
    s0 = start_cnt;
    wr("start2", 6'h00, 32'h1, 2'b00);
    repeat (2) @(negedge tb_ACLK);
    check("start2_pulses", start_cnt - s0, 32'd1);
    @(negedge tb_ACLK);
    S_AXI_BREADY  = 1'b0;
    S_AXI_AWADDR  = 6'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = 32'h0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge tb_ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    check("pend_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    S_AXI_ARESET = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    check("mid_rst_readys", {29'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check("mid_rst_valids", {28'b0, S_AXI_BVALID, S_AXI_RVALID, core_start_o, irq_o}, 32'd0);
    check("mid_rst_bus_a", core_a_o[31:0], 32'h0);
    check("mid_rst_bus_b", core_b_o[127:96], 32'h0);
    S_AXI_ARESET = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    check("post_rst_no_b", {31'b0, S_AXI_BVALID}, 32'd0);
    rd("post_rst_status", 6'h04, 32'h0, 2'b00);
    rd("post_rst_a", 6'h0C, 32'h0, 2'b00);
    s0 = start_cnt;
    wr("start3", 6'h00, 32'h1, 2'b00);
    repeat (2) @(negedge tb_ACLK);
    check("start3_pulses", start_cnt - s0, 32'd1);
    rd("status_busy3", 6'h04, 32'h1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
